// File: rtl/hcms_display_sequencer_if.sv
// Application, column-source, shifter and display-pin signals of the
// HCMS-29xx display sequencer. The sequencer takes the master view.
interface hcms_display_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              FRAME_START_i;
  logic              BRIGHT_UPD_i;
  logic [3:0]        BRIGHT_i;
  logic              READY_o;
  logic              FRAME_DONE_o;
  logic              COL_REQ_o;
  logic [ADDR_W-1:0] COL_ADDR_o;
  logic [7:0]        COL_DATA_i;
  logic              COL_VALID_i;
  logic [7:0]        DATA_o;
  logic              DATA_LOAD_o;
  logic              SHIFT_BUSY_i;
  logic              RS_o;
  logic              CE_n_o;
  logic              DISP_RST_n_o;

  modport master (
    input  FRAME_START_i, BRIGHT_UPD_i, BRIGHT_i, COL_DATA_i, COL_VALID_i,
           SHIFT_BUSY_i,
    output READY_o, FRAME_DONE_o, COL_REQ_o, COL_ADDR_o, DATA_o, DATA_LOAD_o,
           RS_o, CE_n_o, DISP_RST_n_o
  );

  modport slave (
    output FRAME_START_i, BRIGHT_UPD_i, BRIGHT_i, COL_DATA_i, COL_VALID_i,
           SHIFT_BUSY_i,
    input  READY_o, FRAME_DONE_o, COL_REQ_o, COL_ADDR_o, DATA_o, DATA_LOAD_o,
           RS_o, CE_n_o, DISP_RST_n_o
  );
endinterface

// File: rtl/hcms_display_sequencer.sv
// HCMS-29xx display sequencer: pulses the display reset, writes the two
// control words, then serves brightness updates and full dot-data frames
// through the byte-wide serial shifter.
module hcms_display_sequencer #(
  parameter int         NUM_CHARS    = 4,
  parameter int         ADDR_W       = 8,
  parameter int         RST_CYCLES   = 12,
  parameter int         CE_HOLD      = 2,
  parameter logic [1:0] PEAK_CURRENT = 2'b10,
  parameter logic [3:0] BRIGHT_INIT  = 4'hA
) (
  input logic                     CLK_i,
  input logic                     RST_i,
  hcms_display_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(RST_CYCLES + CE_HOLD + 2);
  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(CE_HOLD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CHARS * 5 - 1);

  typedef enum logic [3:0] {
    S_DISP_RST, S_CTRL_SETUP, S_CTRL_LOAD, S_CTRL_WAIT, S_LATCH, S_IDLE,
    S_FRAME_SETUP, S_FETCH, S_LOAD, S_WAIT, S_DONE
  } state_t;

  // Which operation the shared burst/latch states belong to.
  typedef enum logic [1:0] {OP_INIT0, OP_INIT1, OP_BRIGHT, OP_FRAME} op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              seen_busy_q;
  logic [7:0]        data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              frame_pend_q, bright_pend_q;
  logic [3:0]        bright_q;
  logic              take_frame, take_bright;
  logic              rs, ce_n, disp_rst_n, data_load, col_req, ready, frame_done;

  assign take_bright = (state_q == S_IDLE) && (state_d == S_CTRL_SETUP);
  assign take_frame  = (state_q == S_IDLE) && (state_d == S_FRAME_SETUP);

  // Next-state and pin decode; loads are held back while the shifter is busy.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs         = 1'b0;
    ce_n       = 1'b1;
    disp_rst_n = 1'b1;
    data_load  = 1'b0;
    col_req    = 1'b0;
    ready      = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_DISP_RST: begin
        disp_rst_n = 1'b0;
        if (cnt_q == RST_LAST) begin
          state_d = S_CTRL_SETUP;
          op_d    = OP_INIT0;
        end
      end
      S_CTRL_SETUP: begin
        rs      = 1'b1;
        ce_n    = 1'b0;
        state_d = S_CTRL_LOAD;
      end
      S_CTRL_LOAD: begin
        rs   = 1'b1;
        ce_n = 1'b0;
        if (!bus.SHIFT_BUSY_i) begin
          data_load = 1'b1;
          state_d   = S_CTRL_WAIT;
        end
      end
      S_CTRL_WAIT: begin
        rs   = 1'b1;
        ce_n = 1'b0;
        if (seen_busy_q && !bus.SHIFT_BUSY_i) state_d = S_LATCH;
      end
      S_LATCH: begin
        rs = (op_q != OP_FRAME);
        if (cnt_q == HOLD_LAST) begin
          case (op_q)
            OP_INIT0: begin
              state_d = S_CTRL_SETUP;
              op_d    = OP_INIT1;
            end
            OP_FRAME: state_d = S_DONE;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_IDLE: begin
        ready = !frame_pend_q && !bright_pend_q;
        if (bright_pend_q) begin
          state_d = S_CTRL_SETUP;
          op_d    = OP_BRIGHT;
        end else if (frame_pend_q) begin
          state_d = S_FRAME_SETUP;
          op_d    = OP_FRAME;
        end
      end
      S_FRAME_SETUP: begin
        ce_n    = 1'b0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        ce_n    = 1'b0;
        col_req = 1'b1;
        if (bus.COL_VALID_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        ce_n = 1'b0;
        if (!bus.SHIFT_BUSY_i) begin
          data_load = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        ce_n = 1'b0;
        if (seen_busy_q && !bus.SHIFT_BUSY_i)
          state_d = (addr_q == LAST_ADDR) ? S_LATCH : S_FETCH;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_DISP_RST;
    endcase
  end

  // State register plus the dwell counter and busy-rise tracker, both restarting on every state change.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q     <= S_DISP_RST;
      op_q        <= OP_INIT0;
      cnt_q       <= '0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= (state_d == state_q) ? cnt_q + 1'b1 : '0;
      seen_busy_q <= (state_d == state_q) ? (seen_busy_q | bus.SHIFT_BUSY_i) : 1'b0;
    end
  end

  // Byte for the shifter: control word fixed on burst entry, column byte captured on valid.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      data_q <= '0;
    end else if (state_d == S_CTRL_SETUP && state_q != S_CTRL_SETUP) begin
      data_q <= (op_d == OP_INIT1) ? 8'h80 : {2'b01, PEAK_CURRENT, bright_q};
    end else if (state_q == S_FETCH && bus.COL_VALID_i) begin
      data_q <= bus.COL_DATA_i;
    end
  end

  // Column index walks the frame and returns to zero once the frame is done.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      addr_q <= '0;
    end else if (state_q == S_WAIT && state_d == S_FETCH) begin
      addr_q <= addr_q + 1'b1;
    end else if (state_q == S_DONE) begin
      addr_q <= '0;
    end
  end

  // One-deep request flags; a request in the take cycle re-arms its flag.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      frame_pend_q  <= 1'b0;
      bright_pend_q <= 1'b0;
      bright_q      <= BRIGHT_INIT;
    end else if (state_q != S_DISP_RST) begin
      frame_pend_q  <= bus.FRAME_START_i | (frame_pend_q & ~take_frame);
      bright_pend_q <= bus.BRIGHT_UPD_i | (bright_pend_q & ~take_bright);
      if (bus.BRIGHT_UPD_i) bright_q <= bus.BRIGHT_i;
    end
  end

  assign bus.READY_o      = ready;
  assign bus.FRAME_DONE_o = frame_done;
  assign bus.COL_REQ_o    = col_req;
  assign bus.COL_ADDR_o   = addr_q;
  assign bus.DATA_o       = data_q;
  assign bus.DATA_LOAD_o  = data_load;
  assign bus.RS_o         = rs;
  assign bus.CE_n_o       = ce_n;
  assign bus.DISP_RST_n_o = disp_rst_n;

endmodule
